// File: rtl/ir_mem_pkg.sv
// Shared types and constants for the IR memory scheduler: controller state
// encoding and impulse-response sizing defaults.
package ir_mem_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_ARMING    = 2'd1,
        ST_CAPTURING = 2'd2,
        ST_READY     = 2'd3
    } state_t;

    localparam int IR_LENGTH_DEFAULT = 24000;
    localparam int SAMPLE_W          = 16;

endpackage

// File: rtl/ir_memory_scheduler_read_pipe.sv
// Convolution read pipeline: grant -> address -> data valid tracking, plus the
// in-flight read counter used to drain the memory before a measurement.
module ir_read_pipe
    import ir_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                grant,
    input  logic [SAMPLE_W-1:0] mem_rdata,
    output logic                rd_valid,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                drained
);

    logic       vld_p1;
    logic       vld_p2;
    logic [1:0] inflight;

    // Stage p1: address is on the memory bus; stage p2: memory data is present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            inflight <= 2'd0;
        end else begin
            vld_p1   <= grant;
            vld_p2   <= vld_p1;
            inflight <= inflight + {1'b0, grant} - {1'b0, vld_p2};
        end
    end

    // Memory has a registered output, so the data lines are the p2 register.
    assign rd_valid = vld_p2;
    assign rd_data  = vld_p2 ? mem_rdata : '0;
    assign drained  = (inflight == 2'd0);

endmodule

// File: rtl/ir_memory_scheduler.sv
// Arbitrates the single-port IR memory between impulse capture (recorder writes)
// and convolution playback (reads), sequencing measurement requests safely.
module ir_memory_scheduler
    import ir_mem_pkg::*;
#(
    parameter int IMPULSE_LENGTH  = IR_LENGTH_DEFAULT,
    parameter int ADDR_WIDTH      = 15,
    parameter int TIMEOUT_SAMPLES = 48000
) (
    input  logic                  audio_clk,
    input  logic                  rst_in,
    input  logic                  audio_trigger,
    input  logic                  measure_req,
    output logic                  rec_trigger,
    input  logic                  rec_done,
    input  logic                  rec_we,
    input  logic                  rec_valid,
    input  logic [15:0]           rec_addr,
    input  logic [15:0]           rec_data,
    input  logic                  conv_rd_req,
    input  logic [ADDR_WIDTH-1:0] conv_rd_addr,
    output logic                  conv_rd_grant,
    output logic                  conv_rd_valid,
    output logic [15:0]           conv_rd_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic                  ir_valid,
    output logic                  conv_enable,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [15:0]           capture_count
);

    localparam int                TW        = $clog2(TIMEOUT_SAMPLES + 1);
    localparam logic [15:0]       LEN_LIMIT = 16'(IMPULSE_LENGTH);
    localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT_SAMPLES - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              state;
    state_t              state_next;
    logic                start_capture;
    logic                enter_arming;
    logic                accept_wr;
    logic                timeout_hit;
    logic                drained;
    logic [TW-1:0]       timeout_cnt;
    logic signed [15:0]  wr_sample_p0;

    assign conv_rd_grant = conv_rd_req && (state == ST_READY);
    assign accept_wr     = (state == ST_CAPTURING) && rec_valid && rec_we && (rec_addr < LEN_LIMIT);
    assign timeout_hit   = (state == ST_CAPTURING) && audio_trigger && (timeout_cnt == TO_LAST);
    assign wr_sample_p0  = rec_data;

    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) state <= ST_EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        start_capture = 1'b0;
        case (state)
            ST_EMPTY:     if (measure_req) state_next = ST_ARMING;
            ST_ARMING: begin
                if (drained) begin
                    state_next    = ST_CAPTURING;
                    start_capture = 1'b1;
                end
            end
            // rec_done takes priority over a simultaneous timeout.
            ST_CAPTURING: begin
                if (rec_done)         state_next = ST_READY;
                else if (timeout_hit) state_next = ST_EMPTY;
            end
            ST_READY:     if (measure_req) state_next = ST_ARMING;
            default:      state_next = ST_EMPTY;
        endcase
    end

    assign enter_arming = (state_next == ST_ARMING) && (state != ST_ARMING);

    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            rec_trigger   <= 1'b0;
            timeout_cnt   <= '0;
            timeout_err   <= 1'b0;
            capture_count <= '0;
            ir_valid      <= 1'b0;
        end else begin
            rec_trigger <= start_capture;
            ir_valid    <= (state_next == ST_READY);

            if (start_capture)
                timeout_cnt <= '0;
            else if ((state == ST_CAPTURING) && audio_trigger && !timeout_hit)
                timeout_cnt <= timeout_cnt + TW'(1);

            if (enter_arming)
                timeout_err <= 1'b0;
            else if (timeout_hit && !rec_done)
                timeout_err <= 1'b1;

            if (enter_arming)
                capture_count <= '0;
            else if (accept_wr)
                capture_count <= sat_inc16(capture_count);
        end
    end

    // Stage p0 -> p1: registered memory port; grants and writes never coincide
    // because they live in mutually exclusive states.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (conv_rd_grant) begin
                mem_addr <= conv_rd_addr;
            end else if (accept_wr) begin
                mem_addr  <= rec_addr[ADDR_WIDTH-1:0];
                mem_we    <= 1'b1;
                mem_wdata <= wr_sample_p0;
            end
        end
    end

    ir_read_pipe u_read_pipe (
        .clk       (audio_clk),
        .rst       (rst_in),
        .grant     (conv_rd_grant),
        .mem_rdata (mem_rdata),
        .rd_valid  (conv_rd_valid),
        .rd_data   (conv_rd_data),
        .drained   (drained)
    );

    assign busy        = (state == ST_ARMING) || (state == ST_CAPTURING);
    assign conv_enable = ir_valid && (state == ST_READY);

endmodule

// File: tb/tb_ir_memory_scheduler.sv
// Directed bench for ir_memory_scheduler with a behavioural single-port BRAM.
module tb_ir_memory_scheduler;

    logic        audio_clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        audio_trigger = 1'b0;
    logic        measure_req = 1'b0;
    logic        rec_trigger;
    logic        rec_done = 1'b0;
    logic        rec_we = 1'b0;
    logic        rec_valid = 1'b0;
    logic [15:0] rec_addr = '0;
    logic [15:0] rec_data = '0;
    logic        conv_rd_req = 1'b0;
    logic [14:0] conv_rd_addr = '0;
    logic        conv_rd_grant;
    logic        conv_rd_valid;
    logic [15:0] conv_rd_data;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        ir_valid;
    logic        conv_enable;
    logic        busy;
    logic        timeout_err;
    logic [15:0] capture_count;

    int n_tests = 0;
    int n_fail = 0;
    int trig_count = 0;

    logic [15:0] mem [0:32767];

    always #5 audio_clk = ~audio_clk;

    always @(posedge audio_clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge audio_clk) if (rec_trigger === 1'b1) trig_count++;

    ir_memory_scheduler dut (
        .audio_clk     (audio_clk),
        .rst_in        (rst_in),
        .audio_trigger (audio_trigger),
        .measure_req   (measure_req),
        .rec_trigger   (rec_trigger),
        .rec_done      (rec_done),
        .rec_we        (rec_we),
        .rec_valid     (rec_valid),
        .rec_addr      (rec_addr),
        .rec_data      (rec_data),
        .conv_rd_req   (conv_rd_req),
        .conv_rd_addr  (conv_rd_addr),
        .conv_rd_grant (conv_rd_grant),
        .conv_rd_valid (conv_rd_valid),
        .conv_rd_data  (conv_rd_data),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .ir_valid      (ir_valid),
        .conv_enable   (conv_enable),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .capture_count (capture_count)
    );

    task automatic tick();
        @(posedge audio_clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_tests++;
        if ({rec_trigger, conv_rd_grant, conv_rd_valid, mem_we, ir_valid, conv_enable, busy, timeout_err} !== 8'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b required 00000000",
                {rec_trigger, conv_rd_grant, conv_rd_valid, mem_we, ir_valid, conv_enable, busy, timeout_err});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, capture_count, conv_rd_data} !== 63'd0) begin
            n_fail++; $display("FAIL reset_buses: addr %0d wdata %0d count %0d rdata %0d required all 0",
                mem_addr, mem_wdata, capture_count, conv_rd_data);
        end
        rst_in = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_capture();
        measure_req = 1'b1;
        tick();
        measure_req = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || rec_trigger !== 1'b0) begin
            n_fail++; $display("FAIL arm_entry: busy %b trig %b required 1 0", busy, rec_trigger);
        end
        tick();
        n_tests++;
        if (rec_trigger !== 1'b1) begin n_fail++; $display("FAIL trig_two_cycles: got %b required 1", rec_trigger); end
        tick();
        n_tests++;
        if (rec_trigger !== 1'b0 || trig_count != 1) begin
            n_fail++; $display("FAIL trig_single_pulse: trig %b pulses %0d required 0 1", rec_trigger, trig_count);
        end
        for (int a = 0; a < 24000; a++) begin
            rec_valid = 1'b1; rec_we = 1'b1;
            rec_addr = a[15:0]; rec_data = a[15:0];
            tick();
            if (a == 0) begin
                n_tests++;
                if (mem_we !== 1'b1 || mem_addr !== 15'd0 || mem_wdata !== 16'd0) begin
                    n_fail++; $display("FAIL first_write: we %b addr %0d data %0d required 1 0 0", mem_we, mem_addr, mem_wdata);
                end
            end
        end
        rec_valid = 1'b0; rec_we = 1'b0;
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd23999 || mem_wdata !== 16'd23999) begin
            n_fail++; $display("FAIL last_write: we %b addr %0d data %0d required 1 23999 23999", mem_we, mem_addr, mem_wdata);
        end
        tick();
        n_tests++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL we_one_cycle: got %b required 0", mem_we); end
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
        n_tests++;
        if (ir_valid !== 1'b1 || conv_enable !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_ready: ir_valid %b conv_enable %b busy %b required 1 1 0", ir_valid, conv_enable, busy);
        end
        n_tests++;
        if (capture_count !== 16'd24000) begin
            n_fail++; $display("FAIL capture_count: got %0d required 24000", capture_count);
        end
        conv_rd_req = 1'b1; conv_rd_addr = 15'd100;
        #1;
        n_tests++;
        if (conv_rd_grant !== 1'b1) begin n_fail++; $display("FAIL grant_ready: got %b required 1", conv_rd_grant); end
        tick();
        conv_rd_req = 1'b0;
        n_tests++;
        if (mem_addr !== 15'd100 || conv_rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL read_addr_t1: addr %0d valid %b required 100 0", mem_addr, conv_rd_valid);
        end
        tick();
        n_tests++;
        if (conv_rd_valid !== 1'b1 || conv_rd_data !== 16'd100) begin
            n_fail++; $display("FAIL readback_100: valid %b data %0d required 1 100", conv_rd_valid, conv_rd_data);
        end
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 6; i++) begin
            conv_rd_req = (i < 3);
            conv_rd_addr = 15'(5 + i);
            tick();
            n_tests++;
            if (i >= 1 && i <= 3) begin
                if (conv_rd_valid !== 1'b1 || conv_rd_data !== 16'(4 + i)) begin
                    n_fail++; $display("FAIL stream_%0d: valid %b data %0d required 1 %0d", i, conv_rd_valid, conv_rd_data, 4 + i);
                end
            end else if (conv_rd_valid !== 1'b0) begin
                n_fail++; $display("FAIL stream_idle_%0d: valid %b required 0", i, conv_rd_valid);
            end
        end
        conv_rd_req = 1'b0;
    endtask

    task automatic test_measure_during_read();
        conv_rd_req = 1'b1; conv_rd_addr = 15'd200; measure_req = 1'b1;
        #1;
        n_tests++;
        if (conv_rd_grant !== 1'b1) begin n_fail++; $display("FAIL coincident_grant: got %b required 1", conv_rd_grant); end
        tick();
        measure_req = 1'b0; conv_rd_addr = 15'd201;
        #1;
        n_tests++;
        if (conv_rd_grant !== 1'b0 || ir_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL arming_no_grant: grant %b ir_valid %b busy %b required 0 0 1", conv_rd_grant, ir_valid, busy);
        end
        tick();
        conv_rd_req = 1'b0;
        n_tests++;
        if (conv_rd_valid !== 1'b1 || conv_rd_data !== 16'd200 || rec_trigger !== 1'b0) begin
            n_fail++; $display("FAIL drain_read: valid %b data %0d trig %b required 1 200 0", conv_rd_valid, conv_rd_data, rec_trigger);
        end
        tick();
        n_tests++;
        if (conv_rd_valid !== 1'b0 || rec_trigger !== 1'b0) begin
            n_fail++; $display("FAIL drain_gap: valid %b trig %b required 0 0", conv_rd_valid, rec_trigger);
        end
        tick();
        n_tests++;
        if (rec_trigger !== 1'b1) begin n_fail++; $display("FAIL trig_after_drain: got %b required 1", rec_trigger); end
        tick();
    endtask

    task automatic test_ignored_in_capture();
        int trig_before;
        trig_before = trig_count;
        rec_valid = 1'b1; rec_we = 1'b1; rec_addr = 16'd24000; rec_data = 16'h1234;
        measure_req = 1'b1;
        tick();
        rec_valid = 1'b0; rec_we = 1'b0; measure_req = 1'b0;
        n_tests++;
        if (mem_we !== 1'b0 || capture_count !== 16'd0) begin
            n_fail++; $display("FAIL oob_write: we %b count %0d required 0 0", mem_we, capture_count);
        end
        repeat (4) tick();
        n_tests++;
        if (trig_count != trig_before || busy !== 1'b1) begin
            n_fail++; $display("FAIL measure_ignored: pulses %0d busy %b required %0d 1", trig_count, busy, trig_before);
        end
        rec_valid = 1'b1; rec_we = 1'b1; rec_addr = 16'd3; rec_data = 16'hFFFB;
        tick();
        rec_valid = 1'b0; rec_we = 1'b0;
        n_tests++;
        if (mem_we !== 1'b1 || mem_addr !== 15'd3 || mem_wdata !== 16'hFFFB || capture_count !== 16'd1) begin
            n_fail++; $display("FAIL neg_sample: we %b addr %0d data %h count %0d required 1 3 fffb 1",
                mem_we, mem_addr, mem_wdata, capture_count);
        end
    endtask

    task automatic test_timeout();
        audio_trigger = 1'b1;
        for (int i = 0; i < 47999; i++) tick();
        n_tests++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: busy %b err %b required 1 0", busy, timeout_err);
        end
        tick();
        audio_trigger = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || ir_valid !== 1'b0 || conv_enable !== 1'b0) begin
            n_fail++; $display("FAIL timeout_hit: busy %b err %b ir_valid %b enable %b required 0 1 0 0",
                busy, timeout_err, ir_valid, conv_enable);
        end
        conv_rd_req = 1'b1; conv_rd_addr = 15'd7;
        #1;
        n_tests++;
        if (conv_rd_grant !== 1'b0) begin n_fail++; $display("FAIL empty_grant: got %b required 0", conv_rd_grant); end
        tick(); tick();
        conv_rd_req = 1'b0;
        n_tests++;
        if (conv_rd_valid !== 1'b0 || timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL empty_no_read: valid %b err %b required 0 1", conv_rd_valid, timeout_err);
        end
    endtask

    task automatic test_async_reset();
        measure_req = 1'b1;
        tick();
        measure_req = 1'b0;
        n_tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rearm_clear: err %b busy %b required 0 1", timeout_err, busy);
        end
        tick(); tick();
        rec_valid = 1'b1; rec_we = 1'b1; rec_addr = 16'd10; rec_data = 16'd10;
        tick();
        rec_valid = 1'b0; rec_we = 1'b0;
        n_tests++;
        if (mem_we !== 1'b1 || capture_count !== 16'd1) begin
            n_fail++; $display("FAIL pre_reset_write: we %b count %0d required 1 1", mem_we, capture_count);
        end
        #2 rst_in = 1'b1;
        #1;
        n_tests++;
        if ({rec_trigger, conv_rd_grant, conv_rd_valid, mem_we, ir_valid, conv_enable, busy, timeout_err} !== 8'd0
            || mem_addr !== 15'd0 || mem_wdata !== 16'd0 || capture_count !== 16'd0) begin
            n_fail++; $display("FAIL async_reset: we %b busy %b addr %0d wdata %0d count %0d required all 0",
                mem_we, busy, mem_addr, mem_wdata, capture_count);
        end
        tick();
        rst_in = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_empty: busy %b ir_valid %b required 0 0", busy, ir_valid);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_streaming();
        test_measure_during_read();
        test_ignored_in_capture();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
